udma_ctrl_v2: RTL and testbench
===============================

# udma_ctrl_v2

Parametrised second-generation configuration block for the uDMA subsystem. It holds the per-peripheral clock-gate and reset controls, the L2 destination byte and a configurable bank of event comparators. New relative to the first generation: set/clear aliases for clock gates, self-timing reset pulses (with forced clock during reset), per-comparator enables, sticky write-1-to-clear pending flags and registered event outputs. It sits on the uDMA cfg bus next to the channel configuration blocks.

## Interface
- N_PERIPHS, 6: number of peripherals (1..32).
- N_EVT_CMP, 4: number of event comparators; multiple of 4, 4..16.
- RST_CYCLES, 4: length of the reset pulse in clk_i cycles (1..255).
- clk_i  in  1  clock.
- rstn_i  in  1  asynchronous active-low reset.
- cfg_data_i  in  32  write data.
- cfg_addr_i  in  5  word address.
- cfg_valid_i  in  1  access strobe.
- cfg_rwn_i  in  1  1 = read, 0 = write.
- cfg_data_o  out  32  read data; combinational, 0 when not reading.
- cfg_ready_o  out  1  tied to 1.
- rst_value_o  out  N_PERIPHS  per-peripheral reset (active high).
- cg_value_o  out  N_PERIPHS  per-peripheral clock enable.
- cg_core_o  out  1  OR of cg_value_o.
- event_valid_i  in  1  incoming event strobe.
- event_data_i  in  8  incoming event ID.
- event_ready_o  out  1  tied to 1.
- event_o  out  N_EVT_CMP  registered one-cycle match pulses.
- l2_dest_o  out  8  L2 destination byte.

## Operation
- A write happens on a clk_i edge with cfg_valid_i=1 and cfg_rwn_i=0. A read happens with cfg_valid_i=1 and cfg_rwn_i=1. Unmapped addresses read 0 and ignore writes. Bits above N_PERIPHS or N_EVT_CMP read 0.
- 0x00 CG: read/write r_cg.
- 0x01 CG_SET: write sets r_cg bits where data is 1; reads 0.
- 0x02 CG_CLR: write clears r_cg bits where data is 1; reads 0.
- 0x03 RST: write starts a reset pulse on every peripheral whose data bit is 1. Zero bits do not affect pulses already running. Read returns rst_value_o.
- 0x04 L2_DEST: read/write 8-bit, zero-extended.
- 0x05 EVT_EN: read/write comparator enable mask.
- 0x06 EVT_PEND: read returns the sticky pending bits. Writing 1 clears a bit.
- 0x08+k (k < N_EVT_CMP/4) CFG_EVT: comparators 4k..4k+3 in byte lanes 0..3, read/write.
- Each peripheral has its own down-counter, 8 bits wide, with reset value 0.
  - A RST write loads the counter with RST_CYCLES. This includes restarting a pulse that is already running.
  - rst_value_o[i] = (counter != 0). The counter decrements to 0 and saturates there.
- cg_value_o[i] = r_cg[i] OR rst_value_o[i]. The clock is forced on during reset, regardless of r_cg.
- Comparator i matches when event_valid_i=1, EVT_EN[i]=1 and event_data_i equals cmp[i]. Several comparators may match the same event.
- On a match, event_o[i] is registered high for exactly one cycle and pend[i] is set.
- If a set and a W1C clear hit pend[i] on the same edge, the set wins.
- Reset values: r_cg=0, counters=0, cmp=0, EVT_EN=0, pend=0, l2_dest=0, event_o=0. All outputs are therefore 0, except the ready outputs, which are 1.
- Asserting rstn_i mid-pulse drops rst_value_o and cg_value_o to 0 immediately (asynchronous).

## Timing
- Register writes take effect on the edge that samples the write. The new value is visible on outputs and reads in the following cycle.
- Reset pulse: a RST write at edge k gives rst_value_o[i]=1 for cycles k+1 .. k+RST_CYCLES, and 0 after edge k+RST_CYCLES. cg_value_o[i] is 1 in the same window.
- Re-triggering the RST write at edge j during a pulse extends the pulse to end at edge j+RST_CYCLES.
- Event path: event sampled at edge k gives event_o=1 in cycle k+1 only. pend reads 1 from cycle k+1.
- Back-to-back matching events produce event_o high on consecutive cycles, with no gaps.
- Changes to EVT_EN or cmp written at edge k apply to events sampled at edge k+1 and later.
- Reads are combinational in the same cycle; there are no wait states.

## Test plan
- **Reset values:** assert rstn_i, then release it. All registers read 0, and all outputs are 0 except cfg_ready_o and event_ready_o.
- **CG set/clear:** write CG=0x05, then CG_SET=0x0A, then CG_CLR=0x01.
  - CG reads 0x0E and cg_value_o=0x0E.
  - cg_core_o=1; after CG_CLR=0x3F, cg_core_o=0.
- **Reset pulse, re-trigger and async reset:** with RST_CYCLES=4 and r_cg=0, write RST=0x03.
  - rst_value_o and cg_value_o are 0x03 for exactly 4 cycles, then 0.
  - Write RST=0x01 two cycles after the first write: bit 0 is held for 4 more cycles and bit 1 ends on schedule.
  - Assert rstn_i mid-pulse: outputs go to 0 immediately.
- **Event match with enables:** write CFG_EVT0=0x44332211 and EVT_EN=0x5, then send event 0x11, then 0x22.
  - Event 0x11 gives event_o=0x1 one cycle later.
  - Event 0x22 gives no pulse, because comparator 1 is disabled.
  - EVT_PEND reads 0x1.
- **Pending W1C and simultaneous set:** with pend=0x1, write EVT_PEND=0x1 on the same edge that samples a matching event 0x11. pend stays 0x1. A later W1C with no event clears it to 0.
- **Parametrised bank:** with N_EVT_CMP=8, write CFG_EVT1=0x88776655 and EVT_EN=0xF0, then send event 0x77. event_o=0x40, and CFG_EVT1 reads back 0x88776655.

Source files
------------

// File: rtl/udma_ctrl_v2.sv
// ---------------------------------------------------------------------------
// udma_ctrl_v2
// Second-generation uDMA configuration block. It holds the per-peripheral
// clock-gate and reset controls, the L2 destination byte and a bank of event
// comparators with enables and sticky pending flags.
//
// Ports
//   clk_i, rstn_i        clock, asynchronous active-low reset
//   cfg_*                uDMA cfg bus (word address, 1 = read / 0 = write)
//   rst_value_o          per-peripheral reset pulse (active high)
//   cg_value_o           per-peripheral clock enable (forced on during reset)
//   cg_core_o            OR of all clock enables
//   event_valid_i/data_i incoming event strobe and 8-bit ID
//   event_o              registered one-cycle comparator match pulses
//   l2_dest_o            L2 destination byte
//
// Handshake: both the cfg bus and the event input are valid/ready channels
// whose ready is tied to 1, so a transfer happens on every clk_i edge that
// sees valid high. Reads are combinational and complete in the same cycle;
// writes take effect on the sampling edge.
// ---------------------------------------------------------------------------
module udma_ctrl_v2 #(
  parameter int N_PERIPHS  = 6,
  parameter int N_EVT_CMP  = 4,
  parameter int RST_CYCLES = 4
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic [31:0]          cfg_data_i,
  input  logic [4:0]           cfg_addr_i,
  input  logic                 cfg_valid_i,
  input  logic                 cfg_rwn_i,
  output logic [31:0]          cfg_data_o,
  output logic                 cfg_ready_o,
  output logic [N_PERIPHS-1:0] rst_value_o,
  output logic [N_PERIPHS-1:0] cg_value_o,
  output logic                 cg_core_o,
  input  logic                 event_valid_i,
  input  logic [7:0]           event_data_i,
  output logic                 event_ready_o,
  output logic [N_EVT_CMP-1:0] event_o,
  output logic [7:0]           l2_dest_o
);

  localparam int N_BANKS = N_EVT_CMP / 4;

  localparam logic [4:0] ADDR_CG       = 5'h00;
  localparam logic [4:0] ADDR_CG_SET   = 5'h01;
  localparam logic [4:0] ADDR_CG_CLR   = 5'h02;
  localparam logic [4:0] ADDR_RST      = 5'h03;
  localparam logic [4:0] ADDR_L2_DEST  = 5'h04;
  localparam logic [4:0] ADDR_EVT_EN   = 5'h05;
  localparam logic [4:0] ADDR_EVT_PEND = 5'h06;
  localparam logic [4:0] ADDR_CFG_EVT0 = 5'h08;

  localparam logic [7:0] RST_LOAD = 8'(RST_CYCLES);

  logic [N_PERIPHS-1:0] r_cg;
  logic [7:0]           r_cnt [N_PERIPHS];
  logic [7:0]           r_l2_dest;
  logic [N_EVT_CMP-1:0] r_evt_en;
  logic [N_EVT_CMP-1:0] r_pend;
  logic [7:0]           r_cmp [N_EVT_CMP];
  logic [N_EVT_CMP-1:0] r_event;

  logic                 wr_en;
  logic                 rd_en;
  logic [N_EVT_CMP-1:0] match;
  logic [N_EVT_CMP-1:0] pend_w1c;

  assign wr_en = cfg_valid_i & ~cfg_rwn_i;
  assign rd_en = cfg_valid_i &  cfg_rwn_i;

  assign cfg_ready_o   = 1'b1;
  assign event_ready_o = 1'b1;

  // Clock gates: plain write plus set/clear aliases.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_cg <= '0;
    end else if (wr_en) begin
      if (cfg_addr_i == ADDR_CG)
        r_cg <= cfg_data_i[N_PERIPHS-1:0];
      else if (cfg_addr_i == ADDR_CG_SET)
        r_cg <= r_cg | cfg_data_i[N_PERIPHS-1:0];
      else if (cfg_addr_i == ADDR_CG_CLR)
        r_cg <= r_cg & ~cfg_data_i[N_PERIPHS-1:0];
    end
  end

  // Per-peripheral reset pulse counters. A write reloads (and so extends a
  // running pulse); zero data bits leave their counter running untouched.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < N_PERIPHS; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_PERIPHS; i++) begin
        if (wr_en && (cfg_addr_i == ADDR_RST) && cfg_data_i[i])
          r_cnt[i] <= RST_LOAD;
        else if (r_cnt[i] != 8'd0)
          r_cnt[i] <= r_cnt[i] - 8'd1;
      end
    end
  end

  always_comb begin
    rst_value_o = '0;
    for (int i = 0; i < N_PERIPHS; i++) rst_value_o[i] = (r_cnt[i] != 8'd0);
  end

  assign cg_value_o = r_cg | rst_value_o;
  assign cg_core_o  = |cg_value_o;

  // Scalar configuration: L2 destination, comparator enables and IDs.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_l2_dest <= '0;
      r_evt_en  <= '0;
      for (int i = 0; i < N_EVT_CMP; i++) r_cmp[i] <= '0;
    end else if (wr_en) begin
      if (cfg_addr_i == ADDR_L2_DEST) r_l2_dest <= cfg_data_i[7:0];
      if (cfg_addr_i == ADDR_EVT_EN)  r_evt_en  <= cfg_data_i[N_EVT_CMP-1:0];
      for (int k = 0; k < N_BANKS; k++) begin
        if (cfg_addr_i == ADDR_CFG_EVT0 + 5'(k)) begin
          for (int j = 0; j < 4; j++) r_cmp[4*k+j] <= cfg_data_i[8*j +: 8];
        end
      end
    end
  end

  assign l2_dest_o = r_l2_dest;

  // Comparators use the enables/IDs registered before this edge, so a
  // configuration write only affects events sampled on later edges.
  always_comb begin
    match = '0;
    for (int i = 0; i < N_EVT_CMP; i++)
      match[i] = event_valid_i & r_evt_en[i] & (event_data_i == r_cmp[i]);
  end

  assign pend_w1c = (wr_en && (cfg_addr_i == ADDR_EVT_PEND)) ?
                    cfg_data_i[N_EVT_CMP-1:0] : '0;

  // A match on the same edge as a W1C clear wins (OR applied after clear).
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_pend  <= '0;
      r_event <= '0;
    end else begin
      r_pend  <= (r_pend & ~pend_w1c) | match;
      r_event <= match;
    end
  end

  assign event_o = r_event;

  // Combinational read mux; idle bus returns 0.
  always_comb begin
    cfg_data_o = '0;
    if (rd_en) begin
      case (cfg_addr_i)
        ADDR_CG:       cfg_data_o[N_PERIPHS-1:0] = r_cg;
        ADDR_RST:      cfg_data_o[N_PERIPHS-1:0] = rst_value_o;
        ADDR_L2_DEST:  cfg_data_o[7:0]           = r_l2_dest;
        ADDR_EVT_EN:   cfg_data_o[N_EVT_CMP-1:0] = r_evt_en;
        ADDR_EVT_PEND: cfg_data_o[N_EVT_CMP-1:0] = r_pend;
        default: begin
          for (int k = 0; k < N_BANKS; k++) begin
            if (cfg_addr_i == ADDR_CFG_EVT0 + 5'(k)) begin
              for (int j = 0; j < 4; j++) cfg_data_o[8*j +: 8] = r_cmp[4*k+j];
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_udma_ctrl_v2.sv
`timescale 1ns/1ps
module tb_udma_ctrl_v2;

  localparam int NP = 6;
  localparam int NE = 8;
  localparam int RC = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #50 clk = ~clk;

  logic [31:0]   cfg_data = '0;
  logic [4:0]    cfg_addr = '0;
  logic          cfg_valid = 1'b0;
  logic          cfg_rwn = 1'b0;
  logic [31:0]   cfg_data_o;
  logic          cfg_ready_o;
  logic [NP-1:0] rst_value_o;
  logic [NP-1:0] cg_value_o;
  logic          cg_core_o;
  logic          ev_valid = 1'b0;
  logic [7:0]    ev_data = '0;
  logic          event_ready_o;
  logic [NE-1:0] event_o;
  logic [7:0]    l2_dest_o;

  udma_ctrl_v2 #(.N_PERIPHS(NP), .N_EVT_CMP(NE), .RST_CYCLES(RC)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .cfg_data_i(cfg_data), .cfg_addr_i(cfg_addr), .cfg_valid_i(cfg_valid),
    .cfg_rwn_i(cfg_rwn), .cfg_data_o(cfg_data_o), .cfg_ready_o(cfg_ready_o),
    .rst_value_o(rst_value_o), .cg_value_o(cg_value_o), .cg_core_o(cg_core_o),
    .event_valid_i(ev_valid), .event_data_i(ev_data),
    .event_ready_o(event_ready_o), .event_o(event_o), .l2_dest_o(l2_dest_o)
  );

  // ---------------- reference model ----------------
  // Reset pulses are modelled as an absolute end time (edge number) rather
  // than a counter: a peripheral is in reset while edges < m_end[i].
  int          n_cmp = 0;
  int          n_fail = 0;
  int          edges = 0;
  int          m_end [NP];
  logic [31:0] m_cg, m_l2, m_en, m_pend, m_ev;
  logic [7:0]  m_cmp [NE];

  task automatic model_reset();
    for (int i = 0; i < NP; i++) m_end[i] = 0;
    for (int i = 0; i < NE; i++) m_cmp[i] = 8'h00;
    m_cg = 0; m_l2 = 0; m_en = 0; m_pend = 0; m_ev = 0;
  endtask

  function automatic logic [31:0] m_rst();
    logic [31:0] v = 0;
    for (int i = 0; i < NP; i++) v[i] = (edges < m_end[i]);
    return v;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    logic [31:0] v = 0;
    case (a)
      5'h00: v = m_cg;
      5'h03: v = m_rst();
      5'h04: v = m_l2;
      5'h05: v = m_en;
      5'h06: v = m_pend;
      5'h08: v = {m_cmp[3], m_cmp[2], m_cmp[1], m_cmp[0]};
      5'h09: v = {m_cmp[7], m_cmp[6], m_cmp[5], m_cmp[4]};
      default: v = 0;
    endcase
    return v;
  endfunction

  // Applies the effect of the edge about to happen (edge number edges+1).
  task automatic model_edge();
    logic [31:0] hit = 0;
    logic [31:0] w1c = 0;
    logic [31:0] pm = (32'd1 << NP) - 1;
    logic [31:0] em = (32'd1 << NE) - 1;
    for (int i = 0; i < NE; i++)
      if (ev_valid && m_en[i] && ev_data == m_cmp[i]) hit[i] = 1'b1;
    if (cfg_valid && !cfg_rwn) begin
      case (cfg_addr)
        5'h00: m_cg = cfg_data & pm;
        5'h01: m_cg = (m_cg | cfg_data) & pm;
        5'h02: m_cg = m_cg & ~cfg_data;
        5'h03: for (int i = 0; i < NP; i++)
                 if (cfg_data[i]) m_end[i] = edges + 1 + RC;
        5'h04: m_l2 = {24'h0, cfg_data[7:0]};
        5'h05: m_en = cfg_data & em;
        5'h06: w1c = cfg_data & em;
        5'h08: for (int j = 0; j < 4; j++) m_cmp[j]   = cfg_data[8*j +: 8];
        5'h09: for (int j = 0; j < 4; j++) m_cmp[4+j] = cfg_data[8*j +: 8];
        default: ;
      endcase
    end
    m_pend = (m_pend & ~w1c) | hit;
    m_ev   = hit;
  endtask

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ":cg"},   32'(cg_value_o),  m_cg | m_rst());
    chk({tag, ":rst"},  32'(rst_value_o), m_rst());
    chk({tag, ":core"}, 32'(cg_core_o),   32'(|(m_cg | m_rst())));
    chk({tag, ":evt"},  32'(event_o),     m_ev);
    chk({tag, ":l2"},   32'(l2_dest_o),   m_l2);
  endtask

  task automatic rd_expect(input string tag, input logic [4:0] a, input logic [31:0] exp);
    cfg_valid = 1'b1; cfg_rwn = 1'b1; cfg_addr = a;
    #1;
    chk(tag, cfg_data_o, exp);
    cfg_valid = 1'b0; cfg_rwn = 1'b0;
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    edges++;
    cfg_valid = 1'b0; cfg_rwn = 1'b0; ev_valid = 1'b0;
    #1;
    check_outputs(tag);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input string tag);
    cfg_valid = 1'b1; cfg_rwn = 1'b0; cfg_addr = a; cfg_data = d;
    step(tag);
  endtask

  task automatic evt(input logic [7:0] id, input string tag);
    ev_valid = 1'b1; ev_data = id;
    step(tag);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    model_reset();
    repeat (2) begin @(posedge clk); #1; edges++; end
    rstn = 1'b1;
    #1;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    model_reset();
    do_reset();

    // Reset values
    chk("rst:cfg_ready", 32'(cfg_ready_o), 32'd1);
    chk("rst:evt_ready", 32'(event_ready_o), 32'd1);
    chk("rst:cfg_data_idle", cfg_data_o, 32'd0);
    check_outputs("rst");
    for (int a = 0; a < 16; a++) rd_expect("rst:reg", 5'(a), 32'd0);

    // CG set/clear
    wr(5'h00, 32'h05, "cg_wr");
    wr(5'h01, 32'h0A, "cg_set");
    wr(5'h02, 32'h01, "cg_clr");
    rd_expect("cg:read", 5'h00, 32'h0E);
    chk("cg:value", 32'(cg_value_o), 32'h0E);
    chk("cg:core", 32'(cg_core_o), 32'd1);
    rd_expect("cg_set:read0", 5'h01, 32'd0);
    wr(5'h02, 32'h3F, "cg_clr_all");
    chk("cg:core_off", 32'(cg_core_o), 32'd0);

    // Reset pulse: exactly RC cycles
    wr(5'h03, 32'h03, "pulse_wr");
    chk("pulse:rst_c1", 32'(rst_value_o), 32'h03);
    for (int c = 2; c <= RC; c++) begin
      step("pulse_hold");
      chk("pulse:rst_hold", 32'(rst_value_o), 32'h03);
      chk("pulse:cg_hold", 32'(cg_value_o), 32'h03);
    end
    step("pulse_end");
    chk("pulse:rst_end", 32'(rst_value_o), 32'h00);

    // Re-trigger bit 0 two cycles after the first write
    wr(5'h03, 32'h03, "retrig_wr1");
    step("retrig_idle");
    wr(5'h03, 32'h01, "retrig_wr2");
    rd_expect("retrig:read", 5'h03, 32'h03);
    step("retrig_k3");
    chk("retrig:k3", 32'(rst_value_o), 32'h03);
    step("retrig_k4");
    chk("retrig:k4", 32'(rst_value_o), 32'h01);
    step("retrig_k5");
    chk("retrig:k5", 32'(rst_value_o), 32'h01);
    step("retrig_k6");
    chk("retrig:k6", 32'(rst_value_o), 32'h00);

    // Asynchronous reset mid-pulse
    wr(5'h00, 32'h30, "async_cg");
    wr(5'h03, 32'h03, "async_pulse");
    rstn = 1'b0;
    #1;
    chk("async:rst", 32'(rst_value_o), 32'h00);
    chk("async:cg", 32'(cg_value_o), 32'h00);
    chk("async:core", 32'(cg_core_o), 32'd0);
    do_reset();
    check_outputs("async_post");

    // Event match with enables
    wr(5'h08, 32'h44332211, "evt_cfg");
    wr(5'h05, 32'h5, "evt_en");
    evt(8'h11, "evt_11");
    chk("evt:11", 32'(event_o), 32'h01);
    evt(8'h22, "evt_22");
    chk("evt:22_disabled", 32'(event_o), 32'h00);
    rd_expect("evt:pend", 5'h06, 32'h01);

    // W1C and set on the same edge: set wins
    cfg_valid = 1'b1; cfg_rwn = 1'b0; cfg_addr = 5'h06; cfg_data = 32'h1;
    ev_valid = 1'b1; ev_data = 8'h11;
    step("w1c_race");
    rd_expect("w1c:race_pend", 5'h06, 32'h01);
    wr(5'h06, 32'h1, "w1c_clear");
    rd_expect("w1c:cleared", 5'h06, 32'h00);

    // Second comparator bank
    wr(5'h09, 32'h88776655, "bank_cfg");
    wr(5'h05, 32'hF0, "bank_en");
    evt(8'h77, "bank_77");
    chk("bank:evt", 32'(event_o), 32'h40);
    rd_expect("bank:read", 5'h09, 32'h88776655);
    evt(8'h55, "b2b_1");
    chk("b2b:1", 32'(event_o), 32'h10);
    evt(8'h55, "b2b_2");
    chk("b2b:2", 32'(event_o), 32'h10);
    wr(5'h04, 32'hABCD_1234, "l2_wr");
    rd_expect("l2:read", 5'h04, 32'h34);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        cfg_valid = 1'b1; cfg_rwn = 1'b0;
        cfg_addr = 5'($urandom_range(0, 15));
        cfg_data = $urandom;
      end
      if ($urandom_range(0, 1) == 1) begin
        ev_valid = 1'b1;
        ev_data = ($urandom_range(0, 3) != 0) ? m_cmp[$urandom_range(0, NE-1)]
                                              : 8'($urandom_range(0, 255));
      end
      step("rand");
      begin
        logic [4:0] ra;
        ra = 5'($urandom_range(0, 15));
        rd_expect("rand:read", ra, m_read(ra));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
